// File: rtl/tc_pkg.sv
// tc_pkg: shared FSM encoding and sizing helpers for the psum drain path.
package tc_pkg;

    localparam int ELEM_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    function automatic int beats(input int n, input int lanes);
        return n / lanes;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tc_row_fifo.sv
// tc_row_fifo: synchronous row FIFO with async active-low reset; count/full/empty exposed.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module tc_row_fifo
    import tc_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 2,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = r_count == '0;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rp];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= nxt(r_wp);
            end
            if (w_pop) r_rp <= nxt(r_rp);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/tc_psum_drain.sv
// tc_psum_drain: requests a tile's psum rows under credit control and serializes them onto a beat stream.
// Define TC_PSUM_DRAIN_RELU_EN to clamp negative output elements to zero.
module tc_psum_drain
    import tc_pkg::*;
#(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int DW_DATA    = ELEM_W,
    parameter int DW_POS     = 4,
    parameter int OUT_LANES  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         psum_req,
    output logic [DW_POS-1:0]            psum_row,
    input  logic                         psum_valid,
    input  logic [N*DW_DATA-1:0]         psum_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [OUT_LANES*DW_DATA-1:0] m_data,
    output logic [DW_POS-1:0]            m_row,
    output logic                         m_last,
    output logic                         err_ovf
);

    localparam int BEATS = beats(N, OUT_LANES);
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int LW    = OUT_LANES * DW_DATA;
    localparam int CW    = cnt_w(FIFO_DEPTH);

    state_t               r_state, w_next;
    logic                 r_req, r_err;
    logic [DW_POS:0]      r_req_idx;
    logic [DW_POS-1:0]    r_psum_row, r_pop_row;
    logic [BW-1:0]        r_beat;
    logic [CW-1:0]        r_inflight, w_count;
    logic [N*DW_DATA-1:0] w_head;
    logic [LW-1:0]        w_slice;
    logic                 w_full, w_empty, w_credit, w_issue, w_accept, w_tail, w_pop, w_start;

    tc_row_fifo #(.W(N * DW_DATA), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (psum_valid),
        .i_wdata (psum_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // a pending registered request already owns a FIFO slot
    assign w_credit = (CW+1)'(w_count) + (CW+1)'(r_inflight) + (CW+1)'(r_req) < (CW+1)'(FIFO_DEPTH);
    assign w_start  = r_state == S_IDLE && start;
    assign w_issue  = r_state == S_RUN && r_req_idx < (DW_POS+1)'(M) && w_credit;
    assign w_accept = m_valid && m_ready;
    assign w_tail   = r_beat == BW'(BEATS - 1);
    assign w_pop    = w_accept && w_tail;

    assign busy     = r_state != S_IDLE;
    assign done     = r_state == S_DONE;
    assign psum_req = r_req;
    assign psum_row = r_psum_row;
    assign m_valid  = !w_empty;
    assign m_row    = r_pop_row;
    assign m_last   = m_valid && r_pop_row == DW_POS'(M - 1) && w_tail;
    assign err_ovf  = r_err;
    assign w_slice  = w_head[r_beat * LW +: LW];

    always_comb begin
        m_data = w_slice;
`ifdef TC_PSUM_DRAIN_RELU_EN
        for (int j = 0; j < OUT_LANES; j++)
            if (w_slice[j*DW_DATA + DW_DATA - 1]) m_data[j*DW_DATA +: DW_DATA] = '0;
`endif
    end

    always_comb begin
        w_next = r_state;
        if (w_start) w_next = S_RUN;
        if (r_state == S_RUN && r_req && r_psum_row == DW_POS'(M - 1)) w_next = S_DRAIN;
        if (r_state == S_DRAIN && w_pop && m_last && r_inflight == '0) w_next = S_DONE;
        if (r_state == S_DONE) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_err      <= 1'b0;
            r_inflight <= '0;
            r_req_idx  <= '0;
            r_psum_row <= '0;
            r_pop_row  <= '0;
            r_beat     <= '0;
        end else begin
            r_state    <= w_next;
            r_req      <= w_issue;
            r_inflight <= r_inflight + CW'(r_req) - CW'(psum_valid);
            r_err      <= r_err | (psum_valid && w_full && !w_pop);
            if (w_issue) begin
                r_psum_row <= r_req_idx[DW_POS-1:0];
                r_req_idx  <= r_req_idx + 1'b1;
            end
            if (w_start) begin
                r_req_idx <= '0;
                r_pop_row <= '0;
                r_beat    <= '0;
            end else if (w_accept) begin
                r_beat <= w_tail ? '0 : r_beat + 1'b1;
                if (w_tail) r_pop_row <= r_pop_row + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tc_psum_drain.sv
// tb_tc_psum_drain: directed bench for tc_psum_drain; upstream line model with configurable latency.
module tb_tc_psum_drain;

    localparam int N = 16, DW = 8;
`ifdef TC_PSUM_DRAIN_RELU_EN
    localparam logic [31:0] EXP_LAST  = 32'h0000_0000;
    localparam logic [31:0] EXP_RELU0 = 32'h7F00_7F00;
`else
    localparam logic [31:0] EXP_LAST  = 32'hFFFE_FDFC;
    localparam logic [31:0] EXP_RELU0 = 32'h7F80_7F80;
`endif

    logic          clk = 0, rst_n = 0, start = 0, psum_valid = 0, m_ready = 0;
    logic [N*DW-1:0] psum_data = '0;
    logic          busy, done, psum_req, m_valid, m_last, err_ovf;
    logic [3:0]    psum_row, m_row;
    logic [31:0]   m_data;

    int   n_chk = 0, n_err = 0, n_beats = 0, n_req = 0, n_done = 0, lat = 1;
    bit   pat = 0, rnd = 0;
    logic [31:0] first_data, last_data;
    logic [3:0]  last_row;
    logic        last_last;

    tc_psum_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .psum_req(psum_req), .psum_row(psum_row), .psum_valid(psum_valid), .psum_data(psum_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row), .m_last(m_last),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] src(input int r, input int i);
        return pat ? ((i % 2) ? 8'h7F : 8'h80) : 8'((r * 16 + i) % 256);
    endfunction

    function automatic logic [7:0] exp_elem(input logic [7:0] v);
`ifdef TC_PSUM_DRAIN_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    logic       pv [0:8];
    logic [3:0] pr [0:8];

    // upstream psum line: answers each request lat cycles later, in order
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= 8; k++) begin
                pv[k] = 0;
                pr[k] = 0;
            end
            psum_valid = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                pv[k] = pv[k+1];
                pr[k] = pr[k+1];
            end
            pv[8] = 0;
            if (psum_req) begin
                pv[lat] = 1;
                pr[lat] = psum_row;
            end
            psum_valid = pv[0];
            for (int i = 0; i < N; i++) psum_data[i*DW +: DW] = src(int'(pr[0]), i);
        end
    end

    logic        stall = 0;
    logic [36:0] held;

    always @(negedge clk) begin
        int r, b;
        logic [31:0] d;
        if (!rst_n) stall = 0;
        else begin
            if (psum_req) n_req++;
            if (done) n_done++;
            if (stall) chk("stall_hold", {m_valid, m_row, m_data, m_last}, {1'b1, held});
            if (m_valid && m_ready) begin
                r = n_beats / 4;
                b = n_beats % 4;
                for (int j = 0; j < 4; j++) d[j*8 +: 8] = exp_elem(src(r, b * 4 + j));
                chk($sformatf("beat%0d", n_beats), {m_row, m_data, m_last}, {4'(r), d, r == 15 && b == 3});
                if (n_beats == 0) first_data = m_data;
                last_data = m_data;
                last_row  = m_row;
                last_last = m_last;
                n_beats++;
            end
            stall = m_valid && !m_ready;
            held  = {m_row, m_data, m_last};
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic job(input string name, input int l, input int stall_cyc, input bit rmode, input bit xs, input bit p);
        int t;
        lat = l; pat = p; rnd = 0;
        n_beats = 0; n_req = 0; n_done = 0;
        m_ready = stall_cyc == 0;
        start = 1;
        step(1);
        start = 0;
        chk({name, "_busy"}, busy, 1);
        if (stall_cyc > 0) begin
            step(stall_cyc);
            chk("credit_reqs", n_req, 2);
            chk("credit_ovf", err_ovf, 0);
            chk("credit_nopop", n_beats, 0);
            m_ready = 1;
        end
        rnd = rmode;
        if (xs) begin
            step(3);
            start = 1;
            step(1);
            start = 0;
        end
        t = 0;
        while (!done && t < 3000) begin
            step(1);
            t++;
        end
        chk({name, "_done_seen"}, done, 1);
        if (xs) begin
            start = 1;
            step(1);
            start = 0;
            chk("start_in_done", busy, 0);
        end else step(1);
        rnd = 0;
        m_ready = 1;
        step(3);
        chk({name, "_beats"}, n_beats, 64);
        chk({name, "_reqs"}, n_req, 16);
        chk({name, "_dones"}, n_done, 1);
        chk({name, "_ovf"}, err_ovf, 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        int t;
        #1;
        chk("reset_outs", {busy, done, psum_req, psum_row, m_valid, m_data, m_row, m_last, err_ovf}, 0);
        step(2);
        rst_n = 1;
        step(2);

        job("basic", 1, 0, 0, 0, 0);
        chk("basic_first", first_data, 32'h0302_0100);
        chk("basic_last", {last_row, last_data, last_last}, {4'd15, EXP_LAST, 1'b1});

        job("credit", 5, 40, 0, 0, 0);
        job("random", 2, 0, 1, 0, 0);
        job("restart", 1, 0, 0, 1, 0);
        job("second", 3, 0, 0, 0, 0);
        chk("second_first", first_data, 32'h0302_0100);

        lat = 1; pat = 0; n_beats = 0; m_ready = 1;
        start = 1;
        step(1);
        start = 0;
        t = 0;
        while (n_beats < 7 && t < 500) begin
            step(1);
            t++;
        end
        chk("rst_mid_beats", n_beats, 7);
        #2 rst_n = 0;
        #1 chk("rst_async_outs", {busy, done, psum_req, psum_row, m_valid, m_data, m_row, m_last, err_ovf}, 0);
        step(2);
        rst_n = 1;
        step(2);
        job("after_rst", 1, 0, 0, 0, 0);
        chk("after_rst_last", {last_row, last_data, last_last}, {4'd15, EXP_LAST, 1'b1});

        job("relu", 1, 0, 0, 0, 1);
        chk("relu_beat0", first_data, EXP_RELU0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tc_psum_drain.md
Name: tc_psum_drain

Overview:
- Downstream consumer of the psum line buffer.
- After a start pulse, it requests all M rows of the tile in order (0..M-1) and buffers returned N-wide rows in a small row FIFO.
- It serializes each row onto a narrower valid/ready stream toward the writeback/store path.
- Outstanding requests are credit-limited, so the FIFO can never overflow and upstream needs no backpressure.

Parameters:
- M, 16, rows per tile (rows requested per job)
- N, 16, elements per row
- DW_DATA, 8, element width (two's complement)
- DW_POS, 4, row index width; 2**DW_POS >= M
- OUT_LANES, 4, elements per output beat; N % OUT_LANES == 0
- FIFO_DEPTH, 2, row FIFO depth (rows); >= 1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job start; ignored unless state is IDLE
- busy  out  1  high from the cycle after an accepted start until DONE completes
- done  out  1  one-cycle pulse when the last beat of the tile is accepted
- psum_req  out  1  one-cycle row read request to the psum line
- psum_row  out  DW_POS  row index for psum_req; held stable until the next request
- psum_valid  in  1  one returned row; exactly one per psum_req, in order, latency >= 1
- psum_data  in  N*DW_DATA  returned row; element i at [i*DW_DATA +: DW_DATA]
- m_valid  out  1  output beat valid
- m_ready  in  1  output beat accepted when m_valid && m_ready
- m_data  out  OUT_LANES*DW_DATA  beat b of row r carries elements b*OUT_LANES .. b*OUT_LANES+OUT_LANES-1
- m_row  out  DW_POS  row index of current beat
- m_last  out  1  high on the final beat of row M-1
- err_ovf  out  1  sticky; set if psum_valid arrives while the FIFO is full

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, FIFO is empty, counters are 0, psum_row is 0. Reset takes effect asynchronously; release is synchronous to clk.
- FSM IDLE -> RUN on start. RUN -> DRAIN in the cycle after row M-1 is requested. DRAIN -> DONE when the FIFO is empty, nothing is in flight, and the final beat is accepted. DONE -> IDLE after one cycle; done=1 during DONE.
- Credit rule: psum_req may assert in RUN only if fifo_count + inflight < FIFO_DEPTH.
  - inflight increments on psum_req and decrements on psum_valid.
  - A request and a response in the same cycle leave inflight unchanged.
- Issue rate: at most one psum_req per cycle. The request row counter runs 0..M-1 and never wraps within a job.
- FIFO: push on psum_valid, pop when the last beat of the head row is accepted. Push and pop in the same cycle at full are legal; count is unchanged.
- Serializer: BEATS = N/OUT_LANES beats per row, beat counter 0..BEATS-1.
  - m_valid = FIFO not empty.
  - m_data is a combinational slice of the head row selected by the beat counter.
  - m_row comes from a pop-side row counter.
  - First beat appears the cycle after the push (registered FIFO).
- Backpressure: while m_valid && !m_ready, m_data, m_row and m_last hold stable. m_valid never drops without acceptance.
- Beat counter wraps to 0 after beat BEATS-1 is accepted; the row counter then increments.
- m_last = (pop row == M-1) && (beat == BEATS-1).
- busy is 1 in RUN, DRAIN and DONE.
- start while busy: ignored with no side effect. start in the DONE cycle: ignored.
- err_ovf cannot fire in correct operation. It is cleared only by reset, and the offending row is dropped.
- Throughput with m_ready held at 1 and upstream latency L: one beat per cycle once FIFO_DEPTH covers L+1 rows.

Optional Feature:
- Macro TC_PSUM_DRAIN_RELU_EN.
- Defined: each element of m_data is clamped to 0 when its sign bit is 1 (ReLU), combinationally on the output slice.
- Not defined: m_data is the raw psum element. No other behaviour differs.

Decomposition:
- Shared package tc_pkg holds:
  - FSM state encoding (IDLE, RUN, DRAIN, DONE)
  - BEATS derivation
  - element type width DW_DATA
  - FIFO count width, $clog2(FIFO_DEPTH+1)
- One sub-module is natural: tc_row_fifo, a parameterized width/depth synchronous FIFO with an async active-low reset, exposing count, full and empty.

Test Plan:
- Basic, defaults, m_ready=1, upstream latency 1, row r element i = r*16+i (mod 256):
  - expect 64 beats in order; beat 0 = {3,2,1,0}
  - last beat m_row=15, m_data={255,254,253,252}, m_last=1
  - done pulses once.
- Credit, upstream latency 5, m_ready=0 for 40 cycles:
  - expect exactly 2 psum_req issued before any pop and err_ovf=0
  - after m_ready=1, all 64 beats arrive correct.
- Random m_ready at 50%:
  - m_data, m_row and m_last are stable during every stalled cycle
  - beat sequence is identical to the basic test.
- start pulsed during RUN and in the DONE cycle:
  - ignored; exactly 16 psum_req per job
  - a second start in IDLE runs a clean second job with row counters restarted at 0.
- rst_n asserted mid-job (after 7 beats):
  - all outputs 0 asynchronously
  - after release a new start yields a full 64-beat job from row 0.
- With TC_PSUM_DRAIN_RELU_EN defined and element value 8'h80 -> output 8'h00; 8'h7F -> 8'h7F.
